// File: rtl/cpu_port_tx.sv
// Nibble-wide CPU output port serialiser: FIFO-buffered writes, start/4 data/stop framing.
// Optional even-parity bit between data and stop when CPU_PORT_TX_PARITY_EN is defined.
module cpu_port_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] port_in,
  input  logic       load,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       TMAX    = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef CPU_PORT_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         timer_q, timer_d;
  logic [1:0]         bit_q, bit_d, bit_nxt;
  logic [3:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [3:0]         mem [FIFO_DEPTH];
  logic               push, pop;

  assign full     = (count_q == DEPTH_C);
  assign busy     = (state_q != IDLE) || (count_q != '0);
  assign tx       = tx_q;
  assign overflow = overflow_q;

  // Frame sequencer; tx_d anticipates the state being entered so the line flop lines up with it
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    bit_nxt = bit_q + 2'd1;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = START;
          timer_d = TMAX;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (timer_q == 8'd0) begin
          state_d = DATA;
          bit_d   = 2'd0;
          timer_d = TMAX;
          tx_d    = shift_q[0];
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      DATA: begin
        if (timer_q == 8'd0) begin
          timer_d = TMAX;
          if (bit_q == 2'd3) begin
`ifdef CPU_PORT_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^shift_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_nxt;
            tx_d  = shift_q[bit_nxt];
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
`ifdef CPU_PORT_TX_PARITY_EN
      PARITY: begin
        if (timer_q == 8'd0) begin
          state_d = STOP;
          timer_d = TMAX;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
`endif
      STOP: begin
        if (timer_q == 8'd0) begin
          state_d = IDLE;
          timer_d = TMAX;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // A full FIFO still accepts a write when the head leaves on the same edge
  always_comb begin
    push       = rst && load && (!full || pop);
    overflow_d = overflow_q || (rst && load && !push);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= 8'd0;
      bit_q      <= 2'd0;
      shift_q    <= 4'd0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= port_in;
    end
  end

endmodule

// File: tb/tb_cpu_port_tx.sv
// Directed bench for cpu_port_tx: reset, single frames, queued frames, overflow, mid-frame reset.
// Honours CPU_PORT_TX_PARITY_EN for frame length and parity expectations.
module tb_cpu_port_tx;

  localparam int C = 4;
`ifdef CPU_PORT_TX_PARITY_EN
  localparam int F = 7 * C;
`else
  localparam int F = 6 * C;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] port_in = 4'd0;
  logic       load = 1'b0;
  logic       tx, busy, full, overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  cpu_port_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .port_in  (port_in),
    .load     (load),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Line level j cycles after the pop edge of a frame carrying v
  function automatic logic exp_tx(input logic [3:0] v, input int j);
    int seg;
    if (j < 0) return 1'b1;
    seg = j / C;
    if (seg == 0) return 1'b0;
    if (seg <= 4) return v[seg-1];
`ifdef CPU_PORT_TX_PARITY_EN
    if (seg == 5) return ^v;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst = 1'b0; load = 1'b1; port_in = 4'hD;
    tick; tick;
    tests_run++;
    if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx got %b want 1", tx); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++;
    if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b want 0", full); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b want 0", overflow); end
    rst = 1'b1; load = 1'b0;
    tick; tick;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_load_ignored busy got %b want 0", busy); end
  endtask

  task automatic test_single_frame(input logic [3:0] v);
    load = 1'b1; port_in = v;
    tick;
    load = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      tests_failed++; $display("FAIL single_edge0 v=%h busy=%b tx=%b want busy=1 tx=1", v, busy, tx);
    end
    for (int k = 1; k <= F + 1; k++) begin
      tick;
      tests_run++;
      if (tx !== exp_tx(v, k - 1)) begin
        tests_failed++; $display("FAIL single_tx v=%h edge %0d got %b want %b", v, k, tx, exp_tx(v, k - 1));
      end
      tests_run++;
      if (busy !== (k <= F)) begin
        tests_failed++; $display("FAIL single_busy v=%h edge %0d got %b want %b", v, k, busy, (k <= F));
      end
    end
  endtask

  task automatic test_back_to_back;
    int fi, j;
    logic e;
    for (int k = 0; k <= 1 + 5 * (F + 1); k++) begin
      load = (k < 5); port_in = 4'(k + 1);
      tick;
      load = 1'b0;
      e = 1'b1;
      if (k >= 1) begin
        fi = (k - 1) / (F + 1);
        j  = (k - 1) % (F + 1);
        if (fi < 5 && j < F) e = exp_tx(4'(fi + 1), j);
      end
      tests_run++;
      if (tx !== e) begin tests_failed++; $display("FAIL b2b_tx edge %0d got %b want %b", k, tx, e); end
      if (k == 3) begin
        tests_run++;
        if (full !== 1'b0) begin tests_failed++; $display("FAIL b2b_full_e3 got %b want 0", full); end
      end
      if (k == 4) begin
        tests_run++;
        if (full !== 1'b1) begin tests_failed++; $display("FAIL b2b_full_e4 got %b want 1", full); end
      end
    end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_end got %b want 0", busy); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_ovf got %b want 0", overflow); end
  endtask

  task automatic test_overflow;
    logic [3:0] vals [5];
    int fi, j;
    logic e;
    vals = '{4'hC, 4'h1, 4'h2, 4'h3, 4'h4};
    for (int k = 0; k <= 1 + 5 * (F + 1); k++) begin
      load = 1'b0;
      if (k == 0) begin load = 1'b1; port_in = 4'hC; end
      if (k >= 2 && k <= 5) begin load = 1'b1; port_in = 4'(k - 1); end
      if (k == 6) begin load = 1'b1; port_in = 4'hF; end
      tick;
      load = 1'b0;
      e = 1'b1;
      if (k >= 1) begin
        fi = (k - 1) / (F + 1);
        j  = (k - 1) % (F + 1);
        if (fi < 5 && j < F) e = exp_tx(vals[fi], j);
      end
      tests_run++;
      if (tx !== e) begin tests_failed++; $display("FAIL ovf_tx edge %0d got %b want %b", k, tx, e); end
      if (k == 5) begin
        tests_run++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          tests_failed++; $display("FAIL ovf_fill full=%b ovf=%b want full=1 ovf=0", full, overflow);
        end
      end
      if (k == 6) begin
        tests_run++;
        if (full !== 1'b1 || overflow !== 1'b1) begin
          tests_failed++; $display("FAIL ovf_drop full=%b ovf=%b want full=1 ovf=1", full, overflow);
        end
      end
    end
    tests_run++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_sticky ovf=%b busy=%b want ovf=1 busy=0", overflow, busy);
    end
    rst = 1'b0;
    tick;
    rst = 1'b1;
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid_frame;
    for (int k = 0; k <= 13; k++) begin
      load = (k == 0 || k == 2 || k == 3);
      port_in = (k == 0) ? 4'h9 : ((k == 2) ? 4'h5 : 4'h6);
      tick;
      load = 1'b0;
      tests_run++;
      if (tx !== exp_tx(4'h9, k - 1)) begin
        tests_failed++; $display("FAIL rstmid_tx edge %0d got %b want %b", k, tx, exp_tx(4'h9, k - 1));
      end
    end
    rst = 1'b0; load = 1'b1; port_in = 4'hE;
    tick;
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_abort tx=%b busy=%b full=%b want 1 0 0", tx, busy, full);
    end
    rst = 1'b1; load = 1'b0;
    tick; tick; tick;
    tests_run++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_idle busy=%b tx=%b want 0 1", busy, tx);
    end
    test_single_frame(4'h3);
  endtask

  initial begin
    test_reset();
    test_single_frame(4'hA);
`ifdef CPU_PORT_TX_PARITY_EN
    test_single_frame(4'h7);
`endif
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
